// File: rtl/wb_load_queue_pkg.sv
// Shared load encodings and bus macros for the load-writeback queue.
// Optional bypass path is enabled with WB_LOAD_BYPASS_EN.
`ifndef WB_LOAD_QUEUE_DEFINES
`define WB_LOAD_QUEUE_DEFINES
`define RegAddrBus   REG_AW-1:0
`define RegBus       DATA_W-1:0
`define CacheDataBus DATA_W-1:0
`define ZeroWord     '0
`define ZeroReg      '0
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`endif

package wb_load_queue_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_load_queue_load_extract.sv
// Combinational byte/half/word select with sign or zero extension.
module load_extract
    import wb_load_queue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [`CacheDataBus] data,
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr_lo,
    output logic [`RegBus]       result
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (addr_lo)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        // half select ignores addr_lo[0]; misaligned halves are not split
        h = addr_lo[1] ? data[31:16] : data[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   result = {{(DATA_W-8){b[7]}}, b};
            F3_LBU:  result = {{(DATA_W-8){1'b0}}, b};
            F3_LH:   result = {{(DATA_W-16){h[15]}}, h};
            F3_LHU:  result = {{(DATA_W-16){1'b0}}, h};
            default: result = data;
        endcase
    end
endmodule

// File: rtl/wb_load_queue.sv
// In-order outstanding-load queue with extraction and registered writeback.
// Define WB_LOAD_BYPASS_EN to add the combinational forwarding outputs.
module wb_load_queue
    import wb_load_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [`RegAddrBus]       issue_rd,
    input  logic [2:0]               issue_funct3,
    input  logic [1:0]               issue_addr_lo,
    output logic                     issue_ready,
    input  logic                     flush,
    input  logic [`CacheDataBus]     i_p_readdata,
    input  logic                     i_p_readdata_valid,
    input  logic                     i_p_waitrequest,
    output logic                     reg_we_o,
    output logic [`RegAddrBus]       reg_waddr_o,
    output logic [`RegBus]           reg_wdata_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic                     wb_done,
    output logic                     orphan_err_o
`ifdef WB_LOAD_BYPASS_EN
    ,
    output logic                     fwd_valid_o,
    output logic [`RegAddrBus]       fwd_rd_o,
    output logic [`RegBus]           fwd_data_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic [1:0]        addr_lo;
        logic              kill;
    } entry_t;

    entry_t          q [DEPTH];
    entry_t          hd;
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic            resp, push, kill_eff, wr_en, orphan;
    logic [`RegBus]  ext;

    assign hd          = q[head];
    assign resp        = i_p_readdata_valid & ~i_p_waitrequest & (count != '0);
    assign orphan      = i_p_readdata_valid & ~i_p_waitrequest & (count == '0);
    assign issue_ready = (count < CW'(DEPTH)) | resp;
    assign push        = issue_valid & issue_ready & ~flush;
    // a flush in the same cycle also kills the entry being popped
    assign kill_eff    = hd.kill | flush;
    assign wr_en       = resp & ~kill_eff & (hd.rd != '0);

    load_extract #(.DATA_W(DATA_W)) u_extract (
        .data    (i_p_readdata),
        .funct3  (hd.funct3),
        .addr_lo (hd.addr_lo),
        .result  (ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            if (flush)
                for (int i = 0; i < DEPTH; i++) q[i].kill <= 1'b1;
            if (push)
                q[tail] <= '{rd: issue_rd, funct3: issue_funct3,
                             addr_lo: issue_addr_lo, kill: 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            reg_we_o     <= `WriteDisable;
            reg_waddr_o  <= `ZeroReg;
            reg_wdata_o  <= `ZeroWord;
            orphan_err_o <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (resp) head <= head + 1'b1;
            count        <= count + CW'(push) - CW'(resp);
            reg_we_o     <= wr_en ? `WriteEnable : `WriteDisable;
            reg_waddr_o  <= wr_en ? hd.rd : `ZeroReg;
            reg_wdata_o  <= wr_en ? ext : `ZeroWord;
            if (orphan) orphan_err_o <= 1'b1;
        end
    end

    assign pending_o = count;
    assign wb_done   = (count == '0) & ~reg_we_o;

`ifdef WB_LOAD_BYPASS_EN
    assign fwd_valid_o = wr_en;
    assign fwd_rd_o    = hd.rd;
    assign fwd_data_o  = ext;
`endif
endmodule

// File: tb/tb_wb_load_queue.sv
// Directed vector bench for wb_load_queue (default build, no bypass).
module tb_wb_load_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_funct3;
    logic [1:0]  issue_addr_lo;
    logic        issue_ready;
    logic        flush;
    logic [31:0] i_p_readdata;
    logic        i_p_readdata_valid;
    logic        i_p_waitrequest;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic [2:0]  pending_o;
    logic        wb_done;
    logic        orphan_err_o;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    wb_load_queue #(.DATA_W(32), .REG_AW(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_funct3(issue_funct3), .issue_addr_lo(issue_addr_lo),
        .issue_ready(issue_ready), .flush(flush),
        .i_p_readdata(i_p_readdata), .i_p_readdata_valid(i_p_readdata_valid),
        .i_p_waitrequest(i_p_waitrequest),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .pending_o(pending_o), .wb_done(wb_done), .orphan_err_o(orphan_err_o)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_funct3 = 0; issue_addr_lo = 0;
        flush = 0; i_p_readdata = 0; i_p_readdata_valid = 0; i_p_waitrequest = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo);
        issue_valid = 1; issue_rd = rd; issue_funct3 = f3; issue_addr_lo = alo;
        tick();
        issue_valid = 0;
    endtask

    task automatic respond(input logic [31:0] d);
        i_p_readdata_valid = 1; i_p_readdata = d;
        tick();
        i_p_readdata_valid = 0;
    endtask

    initial begin
        tbl[0] = '{3'b010, 2'd0, 5'd5,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        tbl[1] = '{3'b000, 2'd3, 5'd1,  32'h80FF7F01, 1'b1, 32'hFFFFFF80};
        tbl[2] = '{3'b100, 2'd2, 5'd2,  32'h80FF7F01, 1'b1, 32'h000000FF};
        tbl[3] = '{3'b001, 2'd2, 5'd3,  32'h80FF7F01, 1'b1, 32'hFFFF80FF};
        tbl[4] = '{3'b101, 2'd0, 5'd4,  32'h80FF7F01, 1'b1, 32'h00007F01};
        tbl[5] = '{3'b000, 2'd0, 5'd6,  32'h80FF7F01, 1'b1, 32'h00000001};
        tbl[6] = '{3'b001, 2'd3, 5'd7,  32'h80FF7F01, 1'b1, 32'hFFFF80FF};
        tbl[7] = '{3'b010, 2'd0, 5'd0,  32'h80FF7F01, 1'b0, 32'h00000000};
        tbl[8] = '{3'b011, 2'd1, 5'd8,  32'h80FF7F01, 1'b1, 32'h80FF7F01};
        tbl[9] = '{3'b100, 2'd1, 5'd31, 32'h80FF7F01, 1'b1, 32'h0000007F};

        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("reset we", reg_we_o, 0);
        chk("reset waddr", reg_waddr_o, 0);
        chk("reset wdata", reg_wdata_o, 0);
        chk("reset pending", pending_o, 0);
        chk("reset wb_done", wb_done, 1);
        chk("reset orphan", orphan_err_o, 0);
        chk("reset issue_ready", issue_ready, 1);

        // LW with waitrequest held for three cycles
        issue(5'd5, 3'b010, 2'd0);
        i_p_readdata_valid = 1; i_p_readdata = 32'hDEADBEEF; i_p_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait we", reg_we_o, 0);
            chk("wait pending", pending_o, 1);
        end
        i_p_waitrequest = 0;
        tick();
        i_p_readdata_valid = 0;
        chk("wait wb we", reg_we_o, 1);
        chk("wait wb waddr", reg_waddr_o, 5);
        chk("wait wb wdata", reg_wdata_o, 32'hDEADBEEF);
        tick();
        chk("wait wb_done", wb_done, 1);
        chk("wait we off", reg_we_o, 0);

        // Extraction table
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].rd, tbl[i].f3, tbl[i].alo);
            respond(tbl[i].rdata);
            chk($sformatf("vec%0d we", i), reg_we_o, tbl[i].exp_we);
            chk($sformatf("vec%0d waddr", i), reg_waddr_o, tbl[i].exp_we ? 32'(tbl[i].rd) : 32'd0);
            chk($sformatf("vec%0d wdata", i), reg_wdata_o, tbl[i].exp_wdata);
            chk($sformatf("vec%0d pending", i), pending_o, 0);
            tick();
            chk($sformatf("vec%0d wb_done", i), wb_done, 1);
        end

        // Fill to DEPTH, then issue alongside a response
        for (int k = 1; k <= 4; k++) issue(5'(k), 3'b010, 2'd0);
        chk("full issue_ready", issue_ready, 0);
        chk("full pending", pending_o, 4);
        issue_valid = 1; issue_rd = 5; issue_funct3 = 3'b010;
        i_p_readdata_valid = 1; i_p_readdata = 32'h101;
        #1;
        chk("full+resp issue_ready", issue_ready, 1);
        tick();
        issue_valid = 0; i_p_readdata_valid = 0;
        chk("full wb1 waddr", reg_waddr_o, 1);
        chk("full wb1 wdata", reg_wdata_o, 32'h101);
        chk("full pending after", pending_o, 4);
        for (int k = 2; k <= 5; k++) begin
            respond(32'h100 + k);
            chk($sformatf("order we%0d", k), reg_we_o, 1);
            chk($sformatf("order waddr%0d", k), reg_waddr_o, k);
            chk($sformatf("order wdata%0d", k), reg_wdata_o, 32'h100 + k);
        end
        chk("order pending end", pending_o, 0);

        // Flush with a dropped same-cycle issue
        issue(5'd10, 3'b010, 2'd0);
        issue(5'd11, 3'b010, 2'd0);
        flush = 1; issue_valid = 1; issue_rd = 9; issue_funct3 = 3'b010;
        tick();
        flush = 0; issue_valid = 0;
        chk("flush pending", pending_o, 2);
        respond(32'h1111);
        chk("flush r1 we", reg_we_o, 0);
        chk("flush r1 pending", pending_o, 1);
        respond(32'h2222);
        chk("flush r2 we", reg_we_o, 0);
        chk("flush r2 pending", pending_o, 0);
        tick();
        chk("flush wb_done", wb_done, 1);
        chk("flush no orphan", orphan_err_o, 0);

        // Flush in the same cycle as the popping response
        issue(5'd12, 3'b010, 2'd0);
        flush = 1;
        respond(32'h3333);
        flush = 0;
        chk("flush+resp we", reg_we_o, 0);
        chk("flush+resp pending", pending_o, 0);

        // Orphan response
        respond(32'h4444);
        chk("orphan we", reg_we_o, 0);
        chk("orphan err", orphan_err_o, 1);
        tick();
        chk("orphan sticky", orphan_err_o, 1);

        // Reset with loads in flight
        for (int k = 1; k <= 3; k++) issue(5'(k), 3'b010, 2'd0);
        chk("pre-rst pending", pending_o, 3);
        rst = 1;
        tick();
        rst = 0;
        chk("rst pending", pending_o, 0);
        chk("rst we", reg_we_o, 0);
        chk("rst wdata", reg_wdata_o, 0);
        chk("rst orphan clr", orphan_err_o, 0);
        chk("rst wb_done", wb_done, 1);
        respond(32'h5555);
        chk("post-rst we", reg_we_o, 0);
        chk("post-rst orphan", orphan_err_o, 1);
        chk("post-rst pending", pending_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
